// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: forwarding, ALU, RegDst/ALU_Src muxing,
// branch target, and an iterative shift-add multiplier that stalls upstream while busy.
//
// state | meaning
// IDLE  | single-cycle ops; a mult launches here
// MUL   | one shift-add iteration per cycle, EX/MEM loads bubbles
// DONE  | product retires into EX/MEM with the held ID/EX controls
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] immediate_value,
  input  logic [31:0] next,
  input  logic [4:0]  rd,
  input  logic [4:0]  rt,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic        branch,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        write_reg,
  input  logic        write_back,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [31:0] ex_mem_fwd_data,
  input  logic [31:0] mem_wb_fwd_data,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_store_data,
  output logic [31:0] o_branch_target,
  output logic        o_zero,
  output logic [4:0]  o_dest_reg,
  output logic        o_branch,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_write_reg,
  output logic        o_write_back
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [31:0]   acc_q, acc_d;

  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] store_data_q, store_data_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        zero_q, zero_d;
  logic [4:0]  dest_reg_q, dest_reg_d;
  logic [4:0]  ctrl_q, ctrl_d;

  logic [31:0] op_a, fwd_b_val, op_b, alu_res, res;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic        is_mult;
  logic        ctrl_en;

  assign funct = immediate_value[5:0];
  assign shamt = immediate_value[10:6];

  always_comb begin
    case (fwd_a)
      2'b01:   op_a = mem_wb_fwd_data;
      2'b10:   op_a = ex_mem_fwd_data;
      default: op_a = data1;
    endcase
    case (fwd_b)
      2'b01:   fwd_b_val = mem_wb_fwd_data;
      2'b10:   fwd_b_val = ex_mem_fwd_data;
      default: fwd_b_val = data2;
    endcase
    op_b = alu_src ? immediate_value : fwd_b_val;
  end

  assign is_mult = (alu_op == 2'b10) && (funct == 6'h18);

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      default: begin
        case (funct)
          6'h20:   alu_res = op_a + op_b;
          6'h22:   alu_res = op_a - op_b;
          6'h24:   alu_res = op_a & op_b;
          6'h25:   alu_res = op_a | op_b;
          6'h2A:   alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
          6'h00:   alu_res = op_b << shamt;
          default: alu_res = 32'd0;
        endcase
      end
    endcase
  end

  // Flush and reset both cancel the stall in the same cycle they are seen.
  assign stall_req = !rst && !flush &&
                     (((state_q == IDLE) && is_mult) || (state_q == MUL));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res      = alu_res;
    ctrl_en  = !flush;
    case (state_q)
      IDLE: begin
        if (is_mult && !flush) begin
          state_d  = MUL;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = 32'd0;
          count_d  = '0;
          ctrl_en  = 1'b0;
        end
      end
      MUL: begin
        ctrl_en = 1'b0;
        if (flush) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_d = DONE;
            count_d = '0;
          end
        end
      end
      DONE: begin
        // The mult is still sitting in ID/EX; return to IDLE without relaunching.
        res     = acc_q;
        state_d = IDLE;
        count_d = '0;
      end
      default: state_d = IDLE;
    endcase

    alu_result_d    = res;
    zero_d          = (res == 32'd0);
    store_data_d    = fwd_b_val;
    branch_target_d = next + (immediate_value << 2);
    dest_reg_d      = reg_dst ? rd : rt;
    ctrl_d          = {branch, mem_read, mem_write, write_reg, write_back} & {5{ctrl_en}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      mcand_q         <= 32'd0;
      mplier_q        <= 32'd0;
      acc_q           <= 32'd0;
      alu_result_q    <= 32'd0;
      store_data_q    <= 32'd0;
      branch_target_q <= 32'd0;
      zero_q          <= 1'b0;
      dest_reg_q      <= 5'd0;
      ctrl_q          <= 5'd0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      mcand_q         <= mcand_d;
      mplier_q        <= mplier_d;
      acc_q           <= acc_d;
      alu_result_q    <= alu_result_d;
      store_data_q    <= store_data_d;
      branch_target_q <= branch_target_d;
      zero_q          <= zero_d;
      dest_reg_q      <= dest_reg_d;
      ctrl_q          <= ctrl_d;
    end
  end

  assign o_alu_result    = alu_result_q;
  assign o_store_data    = store_data_q;
  assign o_branch_target = branch_target_q;
  assign o_zero          = zero_q;
  assign o_dest_reg      = dest_reg_q;
  assign {o_branch, o_mem_read, o_mem_write, o_write_reg, o_write_back} = ctrl_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, branch target, multiplier
// stall/retire, flush and reset abort.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data1, data2, immediate_value, next;
  logic [4:0]  rd, rt;
  logic [1:0]  alu_op;
  logic        alu_src, reg_dst;
  logic        branch, mem_read, mem_write, write_reg, write_back;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] ex_mem_fwd_data, mem_wb_fwd_data;
  logic        flush;
  logic        stall_req;
  logic [31:0] o_alu_result, o_store_data, o_branch_target;
  logic        o_zero;
  logic [4:0]  o_dest_reg;
  logic        o_branch, o_mem_read, o_mem_write, o_write_reg, o_write_back;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .data1(data1), .data2(data2), .immediate_value(immediate_value), .next(next),
    .rd(rd), .rt(rt), .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .write_reg(write_reg), .write_back(write_back),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
    .flush(flush), .stall_req(stall_req),
    .o_alu_result(o_alu_result), .o_store_data(o_store_data),
    .o_branch_target(o_branch_target), .o_zero(o_zero), .o_dest_reg(o_dest_reg),
    .o_branch(o_branch), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_write_reg(o_write_reg), .o_write_back(o_write_back)
  );

  function automatic logic [4:0] ctrl_out();
    return {o_branch, o_mem_read, o_mem_write, o_write_reg, o_write_back};
  endfunction

  task automatic set_defaults();
    data1 = 0; data2 = 0; immediate_value = 0; next = 0;
    rd = 0; rt = 0; alu_op = 2'b00; alu_src = 0; reg_dst = 0;
    branch = 0; mem_read = 0; mem_write = 0; write_reg = 0; write_back = 0;
    fwd_a = 2'b00; fwd_b = 2'b00; ex_mem_fwd_data = 0; mem_wb_fwd_data = 0;
    flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; set_defaults();
    data1 = 32'h55; data2 = 32'h66; write_reg = 1; branch = 1; next = 32'h40;
    step(); step();
    checks++;
    if (o_alu_result !== 32'd0 || o_store_data !== 32'd0 || o_branch_target !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: result=%h store=%h target=%h want 0", o_alu_result, o_store_data, o_branch_target);
    end
    checks++;
    if (ctrl_out() !== 5'd0 || o_dest_reg !== 5'd0 || o_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ctrl=%b dest=%0d zero=%b want 0", ctrl_out(), o_dest_reg, o_zero);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: stall_req=%b want 0", stall_req);
    end
    rst = 0; set_defaults();
    step();
  endtask

  task automatic test_add();
    set_defaults();
    data1 = 5; data2 = 7; alu_op = 2'b10; immediate_value = 32'h20;
    reg_dst = 1; rd = 3; rt = 9; write_reg = 1;
    step();
    checks++;
    if (o_alu_result !== 32'd12) begin
      errors++; $display("FAIL add_result: got %0d want 12", o_alu_result);
    end
    checks++;
    if (o_dest_reg !== 5'd3 || o_write_reg !== 1'b1 || o_zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ctrl: dest=%0d wr=%b zero=%b want 3 1 0", o_dest_reg, o_write_reg, o_zero);
    end
  endtask

  task automatic test_beq();
    set_defaults();
    data1 = 32'h1234; data2 = 32'h1234; alu_op = 2'b01; branch = 1;
    next = 32'h100; immediate_value = 32'd4; rt = 6;
    step();
    checks++;
    if (o_zero !== 1'b1 || o_branch !== 1'b1 || o_dest_reg !== 5'd6) begin
      errors++;
      $display("FAIL beq_flags: zero=%b branch=%b dest=%0d want 1 1 6", o_zero, o_branch, o_dest_reg);
    end
    checks++;
    if (o_branch_target !== 32'h110) begin
      errors++; $display("FAIL beq_target: got %h want 00000110", o_branch_target);
    end
  endtask

  task automatic test_forwarding();
    set_defaults();
    data1 = 20; data2 = 100; alu_op = 2'b10; immediate_value = 32'h22;
    fwd_a = 2'b10; ex_mem_fwd_data = 9; fwd_b = 2'b01; mem_wb_fwd_data = 4;
    step();
    checks++;
    if (o_alu_result !== 32'd5) begin
      errors++; $display("FAIL fwd_sub: got %0d want 5", o_alu_result);
    end
    checks++;
    if (o_store_data !== 32'd4) begin
      errors++; $display("FAIL fwd_store: got %0d want 4", o_store_data);
    end
    fwd_a = 2'b11;
    step();
    checks++;
    if (o_alu_result !== 32'd16) begin
      errors++; $display("FAIL fwd_a11: got %0d want 16", o_alu_result);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      set_defaults();
      alu_op = 2'b10; write_reg = 1;
      case (i)
        0: begin data1 = 32'hF0F0; data2 = 32'hFF00; immediate_value = 32'h24; exp = 32'hF000; end
        1: begin data1 = 32'hF0F0; data2 = 32'hFF00; immediate_value = 32'h25; exp = 32'hFFF0; end
        2: begin data2 = 32'd1; immediate_value = 32'h100; exp = 32'd16; end
        3: begin data1 = 32'hFFFF_FFFB; data2 = 32'd3; immediate_value = 32'h2A; exp = 32'd1; end
        4: begin data1 = 32'd7; data2 = 32'd9; immediate_value = 32'h3F; exp = 32'd0; end
        default: begin alu_op = 2'b00; alu_src = 1; data1 = 32'd10; immediate_value = 32'hFFFF_FFFF; exp = 32'd9; end
      endcase
      step();
      checks++;
      if (o_alu_result !== exp || o_write_reg !== 1'b1) begin
        errors++;
        $display("FAIL alu_op_%0d: result=%h wr=%b want %h 1", i, o_alu_result, o_write_reg, exp);
      end
    end
  endtask

  task automatic test_mult();
    int stall_cnt = 0;
    int bubble_bad = 0;
    set_defaults();
    data1 = 32'hFFFF_FFFF; data2 = 32'd3; alu_op = 2'b10; immediate_value = 32'h18;
    reg_dst = 1; rd = 7; write_reg = 1; write_back = 1;
    #1;
    do begin
      stall_cnt++;
      step();
      if (ctrl_out() !== 5'd0) bubble_bad++;
      if (stall_cnt == 3) begin fwd_a = 2'b10; ex_mem_fwd_data = 32'h55; end
    end while (stall_req === 1'b1 && stall_cnt < 60);
    checks++;
    if (stall_cnt !== 33) begin
      errors++; $display("FAIL mult_stall_len: got %0d cycles want 33", stall_cnt);
    end
    checks++;
    if (bubble_bad !== 0) begin
      errors++; $display("FAIL mult_bubbles: %0d non-bubble cycles want 0", bubble_bad);
    end
    step();
    checks++;
    if (o_alu_result !== 32'hFFFF_FFFD || o_zero !== 1'b0) begin
      errors++; $display("FAIL mult_result: got %h zero=%b want fffffffd 0", o_alu_result, o_zero);
    end
    checks++;
    if (o_write_reg !== 1'b1 || o_write_back !== 1'b1 || o_dest_reg !== 5'd7) begin
      errors++;
      $display("FAIL mult_ctrl: wr=%b wb=%b dest=%0d want 1 1 7", o_write_reg, o_write_back, o_dest_reg);
    end
    set_defaults();
    data1 = 32'd1; data2 = 32'd2; alu_op = 2'b10; immediate_value = 32'h20; write_reg = 1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL mult_relaunch: stall_req=%b want 0", stall_req);
    end
    step();
    checks++;
    if (o_alu_result !== 32'd3) begin
      errors++; $display("FAIL mult_after_add: got %0d want 3", o_alu_result);
    end
  endtask

  task automatic test_flush_mult();
    set_defaults();
    data1 = 32'd6; data2 = 32'd7; alu_op = 2'b10; immediate_value = 32'h18;
    write_reg = 1; write_back = 1; mem_read = 1;
    for (int i = 0; i < 11; i++) step();
    flush = 1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL flush_stall: stall_req=%b want 0", stall_req);
    end
    step();
    checks++;
    if (ctrl_out() !== 5'd0) begin
      errors++; $display("FAIL flush_ctrl: ctrl=%b want 00000", ctrl_out());
    end
    set_defaults();
    data1 = 32'd2; data2 = 32'd3; alu_op = 2'b10; immediate_value = 32'h20; write_reg = 1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL flush_idle: stall_req=%b want 0", stall_req);
    end
    step();
    checks++;
    if (o_alu_result !== 32'd5 || o_write_reg !== 1'b1) begin
      errors++; $display("FAIL flush_then_add: result=%0d wr=%b want 5 1", o_alu_result, o_write_reg);
    end
  endtask

  task automatic test_reset_mid_mul();
    set_defaults();
    data1 = 32'd6; data2 = 32'd7; alu_op = 2'b10; immediate_value = 32'h18;
    write_reg = 1; next = 32'h20;
    for (int i = 0; i < 5; i++) step();
    rst = 1;
    step();
    checks++;
    if (ctrl_out() !== 5'd0 || o_alu_result !== 32'd0 || o_branch_target !== 32'd0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: ctrl=%b result=%h target=%h stall=%b want 0",
               ctrl_out(), o_alu_result, o_branch_target, stall_req);
    end
    rst = 0;
    set_defaults();
    alu_op = 2'b11; alu_src = 1; data1 = 32'hFFFF_FFFF; immediate_value = 32'd0;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: stall_req=%b want 0", stall_req);
    end
    step();
    checks++;
    if (o_alu_result !== 32'd1) begin
      errors++; $display("FAIL slti: got %0d want 1", o_alu_result);
    end
  endtask

  initial begin
    rst = 1;
    set_defaults();
    test_reset();
    test_add();
    test_beq();
    test_forwarding();
    test_alu_ops();
    test_mult();
    test_flush_mult();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage plus EX/MEM pipeline register. Consumes the ID/EX register outputs, applies forwarding, ALU-control decode, ALU_Src and RegDst muxing, and computes the branch target. Registers results and passed-through control into EX/MEM outputs for the MEM stage. Contains an iterative 32-cycle shift-add multiplier (R-type mult, low 32 bits of the product) that stalls upstream stages while it runs.

Parameters:
MUL_CYCLES, 32, iterations of the shift-add multiplier; counter width is clog2(MUL_CYCLES).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
data1, data2  in  32  register operands from ID/EX
immediate_value  in  32  sign-extended immediate; [5:0]=funct, [10:6]=shamt
next  in  32  PC+4 from ID/EX
rd, rt  in  5  RegDst mux inputs
alu_op  in  2  00 add, 01 sub, 10 R-type (funct), 11 slt
alu_src  in  1  1: operand B = immediate
reg_dst  in  1  1: dest = rd, 0: dest = rt
branch, mem_read, mem_write, write_reg, write_back  in  1 each  control from ID/EX
fwd_a, fwd_b  in  2  00 register, 01 MEM/WB data, 10 EX/MEM result, 11 same as 00
ex_mem_fwd_data  in  32  forwarded EX/MEM ALU result
mem_wb_fwd_data  in  32  forwarded MEM/WB write data
flush  in  1  kill instruction in EX
stall_req  out  1  hold PC, IF/ID, ID/EX
o_alu_result  out  32  registered result
o_store_data  out  32  registered forwarded B (before ALU_Src mux)
o_branch_target  out  32  registered next + (immediate_value << 2)
o_zero  out  1  registered (ALU result == 0)
o_dest_reg  out  5  registered RegDst mux output
o_branch, o_mem_read, o_mem_write, o_write_reg, o_write_back  out  1 each  registered control

Behaviour:
- Reset: all outputs 0, stall_req 0, FSM in IDLE, counter 0. Reset overrides flush and the FSM.
- Latency: 1 cycle for non-mult instructions; outputs update on the clock edge after the inputs are presented.
- Operand A = fwd_a mux. Forwarded B = fwd_b mux. Operand B = alu_src ? immediate_value : forwarded B.
- ALU control: alu_op 00 add; 01 sub; 11 signed slt.
- alu_op 10 decodes funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt, 0x00 sll B by shamt, 0x18 mult. Any other funct gives result 0 with controls passed unchanged.
- Arithmetic is 32-bit wrap-around with no overflow trap. slt yields 32'd1 or 32'd0.
- FSM states: IDLE, MUL, DONE.
  - IDLE: if the decoded op is mult and flush=0, then stall_req=1 combinationally. At the edge, latch multiplicand A and multiplier B, clear the accumulator, count=0, go to MUL. The EX/MEM register loads a bubble (all control outputs 0, data don't-care).
  - MUL: stall_req=1. Each cycle, if multiplier bit0 is set, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1. EX/MEM loads a bubble. At count==MUL_CYCLES-1, go to DONE.
  - DONE: stall_req=0. EX/MEM captures acc as o_alu_result plus the held ID/EX controls and dest. Go to IDLE. DONE must not re-launch the mult still held in ID/EX.
- A mult presented at cycle T asserts stall_req during cycles T..T+32 (33 cycles) and retires at the edge ending cycle T+33.
- Flush: at the next edge the EX/MEM control outputs load 0. Any multiply in progress aborts to IDLE and stall_req deasserts in that same cycle. Flush has priority over stall.
- Forwarding inputs are sampled only at mult launch; changes during MUL have no effect.
- o_zero is computed from the ALU result (the product for mult).

Test Plan:
- add R-type: data1=5, data2=7, alu_op=10, funct=0x20, reg_dst=1, rd=3, write_reg=1 -> next edge: o_alu_result=12, o_dest_reg=3, o_write_reg=1, o_zero=0.
- beq: data1=data2=0x1234, alu_op=01, branch=1, next=0x100, imm=4 -> o_zero=1, o_branch_target=0x110, o_branch=1.
- Forwarding: fwd_a=10, ex_mem_fwd_data=9; fwd_b=01, mem_wb_fwd_data=4; sub via funct 0x22 -> o_alu_result=5. Repeat with fwd_a=11 -> uses data1.
- mult: data1=0xFFFFFFFF, data2=3, funct 0x18 at cycle T -> stall_req high for exactly 33 cycles; bubbles (controls 0) during the stall; o_alu_result=0xFFFFFFFD after edge T+33; no second launch.
- Flush mid-mult at count=10 -> stall_req drops that cycle, next edge all EX/MEM controls 0, FSM IDLE. A following add completes in 1 cycle.
- Reset asserted mid-MUL -> next edge all outputs 0 and stall_req 0. slti check: alu_op=11, data1=-1, imm=0 -> o_alu_result=1.
